// File: rtl/ldstr_mem_pipe.sv
// Byte-enabled load/store word memory with a reset-time clear sweep and a one-deep response register.
// Optional per-byte even parity with an rsp_perr output when LDSTR_MEM_PARITY_EN is defined.
module ldstr_mem_pipe #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
`ifdef LDSTR_MEM_PARITY_EN
    output logic                rsp_perr,
`endif
    output logic                init_done
);

    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

    typedef enum logic {INIT, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              acc, oor, wr_en;
    logic [DATA_W-1:0] rd_word, rdata_nxt;

    logic              vld_p1, err_p1;
    logic [DATA_W-1:0] rdata_p1;

    function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0] old_w,
                                                     input logic [DATA_W-1:0] new_w,
                                                     input logic [NB-1:0]     be);
        logic [DATA_W-1:0] r;
        r = old_w;
        for (int i = 0; i < NB; i++)
            if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= INIT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (state == INIT) begin
            if (cnt == LAST) begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt = cnt + 1'b1;
            end
        end
    end

    assign init_done = (state == RUN);
    assign req_ready = init_done & (~vld_p1 | rsp_ready);
    assign acc       = req_valid & req_ready;
    assign oor       = ({1'b0, req_addr} >= DEPTH_V);
    assign wr_en     = acc & req_we & ~oor;
    assign rd_word   = mem[req_addr];
    assign rdata_nxt = (req_we || oor) ? '0 : rd_word;

    // The sweep owns the write port until RUN; memory itself is never reset.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[cnt] <= '0;
        else if (wr_en)
            mem[req_addr] <= byte_merge(mem[req_addr], req_wdata, req_be);
    end

`ifdef LDSTR_MEM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] par_rd;
    logic          perr_p1;

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int i = 0; i < NB; i++) p[i] = ^w[8*i +: 8];
        return p;
    endfunction

    assign par_rd = par[req_addr];

    always_ff @(posedge clk) begin
        if (state == INIT)
            par[cnt] <= '0;
        else if (wr_en)
            par[req_addr] <= (par[req_addr] & ~req_be) | (byte_par(req_wdata) & req_be);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perr_p1 <= 1'b0;
        else if (acc)
            perr_p1 <= ~req_we & ~oor & (|(byte_par(rd_word) ^ par_rd));
    end

    assign rsp_perr = perr_p1;
`endif

    // Response stage p1: held while the consumer stalls, replaced in the same edge it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            rdata_p1 <= '0;
            err_p1   <= 1'b0;
        end else if (acc) begin
            vld_p1   <= 1'b1;
            rdata_p1 <= rdata_nxt;
            err_p1   <= oor;
        end else if (rsp_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    assign rsp_valid = vld_p1;
    assign rsp_rdata = rdata_p1;
    assign rsp_err   = err_p1;

endmodule

// File: tb/tb_ldstr_mem_pipe.sv
// Bench for ldstr_mem_pipe: a DEPTH=16 and a DEPTH=12 instance driven in lockstep, checked by
// directed tables, hand-written stall/reset sequences and a scoreboard model under random traffic.
module tb_ldstr_mem_pipe;

    logic        clk, rst;
    logic        req_valid, req_we, rsp_ready;
    logic [3:0]  req_addr, req_be;
    logic [31:0] req_wdata;

    logic        rr_a, rv_a, er_a, idn_a, rr_b, rv_b, er_b, idn_b;
    logic [31:0] rd_a, rd_b;
`ifdef LDSTR_MEM_PARITY_EN
    logic        pe_a, pe_b;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ldstr_mem_pipe #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_a), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv_a),
        .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(er_a),
`ifdef LDSTR_MEM_PARITY_EN
        .rsp_perr(pe_a),
`endif
        .init_done(idn_a));

    ldstr_mem_pipe #(.DATA_W(32), .DEPTH(12), .ADDR_W(4)) dut_b (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rr_b), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be), .rsp_valid(rv_b),
        .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(er_b),
`ifdef LDSTR_MEM_PARITY_EN
        .rsp_perr(pe_b),
`endif
        .init_done(idn_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dep(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    // Scoreboard: expected responses of both instances, in acceptance order.
    typedef struct packed {
        logic [1:0][31:0] rd;
        logic [1:0]       er;
    } sb_t;
    sb_t         sbq[$];
    logic [31:0] mm [2][16];

    always @(negedge clk) begin
        logic        rv [2], rr [2], er [2], idn [2];
        logic [31:0] rd [2];
        logic        ei;
        sb_t         e;
        rv[0] = rv_a; rv[1] = rv_b; rr[0] = rr_a; rr[1] = rr_b;
        er[0] = er_a; er[1] = er_b; idn[0] = idn_a; idn[1] = idn_b;
        rd[0] = rd_a; rd[1] = rd_b;
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                chk("rst_rsp_valid", 32'(rv[i]), 0);
                chk("rst_rsp_rdata", rd[i], 0);
                chk("rst_rsp_err", 32'(er[i]), 0);
                chk("rst_init_done", 32'(idn[i]), 0);
                chk("rst_req_ready", 32'(rr[i]), 0);
            end
            cyc = 0;
            sbq.delete();
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 16; j++) mm[i][j] = '0;
        end else begin
            cyc++;
            for (int i = 0; i < 2; i++) begin
                ei = (cyc > dep(i));
                chk("init_done", 32'(idn[i]), 32'(ei));
                chk("req_ready", 32'(rr[i]), 32'(ei && (!rv[i] || rsp_ready)));
                chk("rsp_valid", 32'(rv[i]), 32'(sbq.size() != 0));
`ifdef LDSTR_MEM_PARITY_EN
                chk("rsp_perr", 32'((i == 0) ? pe_a : pe_b), 0);
`endif
            end
            if (sbq.size() != 0) begin
                e = sbq[0];
                for (int i = 0; i < 2; i++) begin
                    if (rv[i]) begin
                        chk("sb_rdata", rd[i], e.rd[i]);
                        chk("sb_err", 32'(er[i]), 32'(e.er[i]));
                    end
                end
                if (rsp_ready) void'(sbq.pop_front());
            end
            if (req_valid && rr_a) begin
                for (int i = 0; i < 2; i++) begin
                    e.er[i] = (int'(req_addr) >= dep(i));
                    e.rd[i] = (req_we || e.er[i]) ? 32'h0 : mm[i][req_addr];
                    if (req_we && !e.er[i])
                        for (int b = 0; b < 4; b++)
                            if (req_be[b]) mm[i][req_addr][8*b +: 8] = req_wdata[8*b +: 8];
                end
                sbq.push_back(e);
            end
        end
    end

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic txn(input logic we, input logic [3:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rda, output logic era,
                       output logic [31:0] rdb, output logic erb);
        int   n;
        logic done;
        n = 0;
        done = 1'b0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_be = be;
        while (!done) begin
            @(negedge clk);
            done = rr_a;
            @(posedge clk); #1;
            n++;
            if (!done && n >= 100) begin
                total++; bad++;
                $display("FAIL txn_timeout: request not accepted within %0d cycles", n);
                done = 1'b1;
            end
        end
        req_valid = 1'b0;
        chk("txn_rsp_valid", 32'(rv_a), 1);
        rda = rd_a; era = er_a; rdb = rd_b; erb = er_b;
    endtask

    // Counts falling edges from reset release until each instance reports init_done.
    task automatic wait_init(output int na, output int nb);
        na = 0;
        nb = 0;
        while (!idn_a && na < 100) begin
            @(negedge clk);
            na++;
            if (idn_b && nb == 0) nb = na;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wd;
        logic [3:0]  be;
        logic [31:0] ex_a;
        logic        er_a;
        logic [31:0] ex_b;
        logic        er_b;
    } vec_t;

    vec_t        tbl [12];
    logic [31:0] ra, rb;
    logic        ea, eb;
    int          na, nb;

    initial begin
        tbl[0]  = '{1'b0, 4'd0,  32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[1]  = '{1'b0, 4'd15, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[2]  = '{1'b1, 4'd3,  32'hAABBCCDD, 4'hF, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[3]  = '{1'b1, 4'd3,  32'h11223344, 4'h5, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 4'd3,  32'h0,        4'h0, 32'hAA22CC44, 1'b0, 32'hAA22CC44, 1'b0};
        tbl[5]  = '{1'b1, 4'd13, 32'hFFFFFFFF, 4'hF, 32'h0,        1'b0, 32'h0,        1'b1};
        tbl[6]  = '{1'b0, 4'd13, 32'h0,        4'h0, 32'hFFFFFFFF, 1'b0, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 4'd5,  32'h12345678, 4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[8]  = '{1'b0, 4'd5,  32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[9]  = '{1'b1, 4'd11, 32'hCAFEF00D, 4'h8, 32'h0,        1'b0, 32'h0,        1'b0};
        tbl[10] = '{1'b0, 4'd11, 32'h0,        4'h0, 32'hCA000000, 1'b0, 32'hCA000000, 1'b0};
        tbl[11] = '{1'b0, 4'd12, 32'h0,        4'h0, 32'h0,        1'b0, 32'h0,        1'b1};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_wdata = '0; req_be = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wait_init(na, nb);
        chk("init_cycles_a", 32'(na), 17);
        chk("init_cycles_b", 32'(nb), 13);

        for (int a = 0; a < 16; a++) begin
            txn(1'b0, 4'(a), 32'h0, 4'h0, ra, ea, rb, eb);
            chk($sformatf("clear_rd_a%0d", a), ra, 0);
            chk($sformatf("clear_err_a%0d", a), 32'(ea), 0);
            chk($sformatf("clear_rd_b%0d", a), rb, 0);
            chk($sformatf("clear_err_b%0d", a), 32'(eb), 32'(a >= 12));
        end

        for (int k = 0; k < 12; k++) begin
            txn(tbl[k].we, tbl[k].addr, tbl[k].wd, tbl[k].be, ra, ea, rb, eb);
            chk($sformatf("tbl%0d_rd_a", k), ra, tbl[k].ex_a);
            chk($sformatf("tbl%0d_err_a", k), 32'(ea), 32'(tbl[k].er_a));
            chk($sformatf("tbl%0d_rd_b", k), rb, tbl[k].ex_b);
            chk($sformatf("tbl%0d_err_b", k), 32'(eb), 32'(tbl[k].er_b));
        end

        // Consumer stall with a second request waiting behind it.
        idle(1);
        rsp_ready = 1'b0;
        txn(1'b0, 4'd3, 32'h0, 4'h0, ra, ea, rb, eb);
        chk("stall_first_rd", ra, 32'hAA22CC44);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 4'd11;
        repeat (3) begin
            @(posedge clk); #1;
            chk("stall_vld", 32'(rv_a), 1);
            chk("stall_rd", rd_a, 32'hAA22CC44);
            chk("stall_rdy", 32'(rr_a), 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("stall_next_vld", 32'(rv_a), 1);
        chk("stall_next_rd", rd_a, 32'hCA000000);

        // Back-to-back loads at full throughput.
        for (int k = 0; k < 8; k++)
            txn(1'b1, 4'(k), 32'h01010101 * 32'(k + 1), 4'hF, ra, ea, rb, eb);
        req_valid = 1'b1; req_we = 1'b0;
        for (int k = 0; k < 8; k++) begin
            req_addr = 4'(k);
            @(posedge clk); #1;
            chk($sformatf("stream_vld%0d", k), 32'(rv_a), 1);
            chk($sformatf("stream_rd%0d", k), rd_a, 32'h01010101 * 32'(k + 1));
        end
        req_valid = 1'b0;
        idle(1);
        chk("stream_drained", 32'(rv_a), 0);

        // Reset pulse in the middle of the clear sweep.
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        wait_init(na, nb);
        chk("reinit_cycles_a", 32'(na), 17);
        chk("reinit_cycles_b", 32'(nb), 13);

        for (int c = 0; c < 600; c++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = 4'($urandom_range(0, 15));
            req_wdata = $urandom;
            req_be    = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        idle(2);
        chk("sb_empty", 32'(sbq.size()), 0);

        // Reset while a store response is stalled: response dropped, memory re-cleared.
        rsp_ready = 1'b0;
        txn(1'b1, 4'd7, 32'h5A5A5A5A, 4'hF, ra, ea, rb, eb);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        rsp_ready = 1'b1;
        wait_init(na, nb);
        txn(1'b0, 4'd7, 32'h0, 4'h0, ra, ea, rb, eb);
        chk("run_rst_rd_a", ra, 0);
        chk("run_rst_rd_b", rb, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ldstr_mem_pipe.md
LDSTR_MEM_PIPE -- requirements
Module: ldstr_mem_pipe

Interface
REQ-001 Parameter DATA_W, 32, data width in bits; SHALL be a multiple of 8, min 8.
REQ-002 Parameter DEPTH, 16, number of words; SHALL be 2..1024, not necessarily a power of two.
REQ-003 Parameter ADDR_W, 4, address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  block can accept a request this cycle.
REQ-008 req_we  in  1  1 = store, 0 = load.
REQ-009 req_addr  in  ADDR_W  word address.
REQ-010 req_wdata  in  DATA_W  store data.
REQ-011 req_be  in  DATA_W/8  store byte enables; bit i covers byte i.
REQ-012 rsp_valid  out  1  response present.
REQ-013 rsp_ready  in  1  consumer accepts response.
REQ-014 rsp_rdata  out  DATA_W  load data; 0 for stores and errored loads.
REQ-015 rsp_err  out  1  address out of range (req_addr >= DEPTH).
REQ-016 init_done  out  1  memory clear sweep complete.

Function
REQ-017 FSM states SHALL be INIT and RUN; INIT entered on reset, RUN entered the cycle after the last word is cleared.
REQ-018 INIT SHALL write 0 to word k on the k-th cycle after reset release (k = 0..DEPTH-1), taking exactly DEPTH cycles; init_done SHALL assert on the following cycle.
REQ-019 req_ready SHALL equal init_done AND (NOT rsp_valid OR rsp_ready).
REQ-020 A request is accepted when req_valid AND req_ready are both high at a rising edge.
REQ-021 Accepted store with in-range address SHALL update only the bytes whose req_be bit is 1, at the accepting edge.
REQ-022 Accepted load SHALL present the word in rsp_rdata with rsp_valid high on the cycle after acceptance (latency 1).
REQ-023 Every accepted request (load or store) SHALL produce exactly one response; stores return rsp_rdata = 0.
REQ-024 rsp_valid, rsp_rdata, rsp_err SHALL hold stable while rsp_valid=1 and rsp_ready=0.
REQ-025 With rsp_valid=1 and rsp_ready=1, a new request SHALL be accepted in the same cycle (full throughput, one request per cycle).
REQ-026 rsp_valid SHALL drop the cycle after rsp_ready=1 if no new request is accepted that cycle.
REQ-027 Out-of-range address SHALL not modify memory, SHALL return rsp_rdata=0 and rsp_err=1.
REQ-028 Load to the same address immediately after a store SHALL return the stored data.
REQ-029 req_be = 0 on a store SHALL leave memory unchanged but still produce a response.

Reset
REQ-030 On rst assertion: rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0, req_ready=0, state=INIT, sweep counter=0.
REQ-031 rst asserted during INIT or RUN SHALL abort all activity, drop any pending response and restart the sweep from word 0.
REQ-032 Memory contents SHALL be 0 at every address once init_done asserts.

Configuration
REQ-033 Macro LDSTR_MEM_PARITY_EN: when defined, one even-parity bit per byte SHALL be stored on every byte write and the INIT sweep, and checked on load.
REQ-034 With LDSTR_MEM_PARITY_EN defined, output rsp_perr (1 bit) SHALL assert with the load response when any read byte fails parity; 0 for stores, errored loads and at reset.
REQ-035 Without LDSTR_MEM_PARITY_EN, no parity storage and no rsp_perr port SHALL exist; all other behaviour identical.

Verification
REQ-036 Reset release, DEPTH=16 -> req_ready=0 for 16 cycles, init_done=1 on cycle 17; loads of all 16 addresses return 0.
REQ-037 Store addr 3 data 0xAABBCCDD be=4'b1111, then store addr 3 data 0x11223344 be=4'b0101 -> load addr 3 returns 0xAA22CC44, rsp_err=0.
REQ-038 Back-to-back loads addr 0..7 with rsp_ready=1 -> one response per cycle, data in order, latency 1.
REQ-039 Load with rsp_ready held 0 for 3 cycles -> rsp_valid/rsp_rdata stable, req_ready=0 for those cycles, no request lost.
REQ-040 DEPTH=12, store addr 13 data 0xFFFFFFFF -> rsp_err=1, rsp_rdata=0; subsequent loads of 0..11 unchanged.
REQ-041 rst pulse during INIT at cycle 5 -> sweep restarts, init_done asserts DEPTH+1 cycles after release.
